// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control/status bundle for the multi-channel clock divider
// CLK_DIV_GEN_SYNC_EN adds the sync phase-align input to the bundle.
interface clk_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  logic              en;
  logic              div_we;
  logic [3:0]        div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLK_DIV_GEN_SYNC_EN
  logic              sync;

  modport master (output en, div_we, div_ch, div_val, sync, input clk_out, tick);
  modport slave  (input en, div_we, div_ch, div_val, sync, output clk_out, tick);
`else
  modport master (output en, div_we, div_ch, div_val, input clk_out, tick);
  modport slave  (input en, div_we, div_ch, div_val, output clk_out, tick);
`endif
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - NUM_CH independent 50% duty dividers with rising-edge ticks
// Optional macro CLK_DIV_GEN_SYNC_EN: sync input phase-aligns all channels.
module clk_div_gen #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 27,
  parameter int DEFAULT_HALF = 4_999_999
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_active [NUM_CH];
  logic [CNT_W-1:0]  r_shadow [NUM_CH];
  logic [NUM_CH-1:0] r_clk_out;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_tc;

  always_comb begin
    w_wr = '0;
    w_tc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = bus.div_we && (bus.div_ch == 4'(i));
      w_tc[i] = (r_cnt[i] == r_active[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_active[i] <= DEF_DIV;
        r_shadow[i] <= DEF_DIV;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
    end
`ifdef CLK_DIV_GEN_SYNC_EN
    else if (bus.sync) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_active[i] <= r_shadow[i];
        if (w_wr[i]) r_shadow[i] <= bus.div_val;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
    end
`endif
    else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr[i]) r_shadow[i] <= bus.div_val;
        // a write landing on the terminal edge bypasses the shadow
        if (bus.en && w_tc[i]) begin
          r_cnt[i]     <= '0;
          r_clk_out[i] <= ~r_clk_out[i];
          r_tick[i]    <= ~r_clk_out[i];
          r_active[i]  <= w_wr[i] ? bus.div_val : r_shadow[i];
        end else begin
          r_tick[i] <= 1'b0;
          if (bus.en) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
endmodule
